// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling deframer and a
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | half a bit in, confirm start bit is still low
//   DATA  | sample 8 data bits LSB first at mid-bit
//   STOP  | sample stop bit; high pushes the byte, low is a framing error
//   BREAK | line held low after a bad stop bit; wait for it to return high
module uart_rx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_error,
    output logic                          overrun,
    input  logic                          err_clear
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam int PTR_W            = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [CNT_W-1:0]   clk_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               stop_tick;
    logic               push;
    logic               pop;
    logic               full;
    logic               do_push;

    assign stop_tick      = (state == STOP) && (clk_cnt == SYMBOL_LAST);
    assign push           = stop_tick && rx_s;
    assign data_out_valid = (fifo_count != '0);
    assign data_out       = mem[rd_ptr];
    assign pop            = data_out_valid && data_out_ready;
    assign full           = (fifo_count == COUNT_FULL);
    assign do_push        = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= (framing_error && !err_clear) || (stop_tick && !rx_s);
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (clk_cnt == SAMPLE_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (clk_cnt == SYMBOL_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (stop_tick) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? IDLE : BREAK;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    clk_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push writes on the stop-sample edge so the byte is at the head one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun <= (overrun && !err_clear) || (push && full && !pop);
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: table of single-byte frames plus
// hand-written sequences for streaming, overrun, framing, glitch and reset cases.
module tb_uart_rx_buffered;
    // A faster line rate keeps the run short; all waits scale with BIT.
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 460_800;
    localparam int DEPTH  = 4;
    localparam int BIT    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic [2:0] fifo_count;
    logic       framing_error;
    logic       overrun;
    logic       err_clear;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] popped [$];
    logic [7:0] exp_q  [$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic [2:0] exp_count;
        logic       exp_fe;
    } vec_t;
    vec_t vecs [3];

    uart_rx_buffered #(
        .CLOCK_FREQ(CLK_HZ),
        .BAUD_RATE (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .fifo_count    (fifo_count),
        .framing_error (framing_error),
        .overrun       (overrun),
        .err_clear     (err_clear)
    );

    always #10 clk = ~clk;

    // Inputs change 1 ns after posedge, so a handshake seen here pops on the next edge.
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready) popped.push_back(data_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_clks(BIT);
        end
        serial_in = stop_bit;
        wait_clks(BIT);
    endtask

    task automatic pop_all(input int n);
        data_out_ready = 1'b1;
        wait_clks(n);
        data_out_ready = 1'b0;
        wait_clks(1);
    endtask

    task automatic check_popped(input string name);
        check({name, "_len"}, 32'(popped.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d", name, i),
                  32'((i < popped.size()) ? popped[i] : 8'hxx), 32'(exp_q[i]));
        end
    endtask

    initial begin
        vecs[0] = '{tx: 8'h00, exp_data: 8'h00, exp_valid: 1'b1, exp_count: 3'd1, exp_fe: 1'b0};
        vecs[1] = '{tx: 8'hff, exp_data: 8'hff, exp_valid: 1'b1, exp_count: 3'd1, exp_fe: 1'b0};
        vecs[2] = '{tx: 8'h96, exp_data: 8'h96, exp_valid: 1'b1, exp_count: 3'd1, exp_fe: 1'b0};

        rst            = 1'b1;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
        err_clear      = 1'b0;
        wait_clks(3);
        check("rst_data",  32'(data_out), 32'h0);
        check("rst_valid", 32'(data_out_valid), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_fe",    32'(framing_error), 32'h0);
        check("rst_ov",    32'(overrun), 32'h0);
        rst = 1'b0;
        wait_clks(BIT);

        for (int v = 0; v < 3; v++) begin
            send_frame(vecs[v].tx, 1'b1);
            wait_clks(2);
            check($sformatf("vec%0d_data", v),  32'(data_out), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_valid", v), 32'(data_out_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_count", v), 32'(fifo_count), 32'(vecs[v].exp_count));
            check($sformatf("vec%0d_fe", v),    32'(framing_error), 32'(vecs[v].exp_fe));
            pop_all(1);
            check($sformatf("vec%0d_count_after_pop", v), 32'(fifo_count), 32'h0);
        end

        // Single byte with consumer always ready.
        popped.delete();
        data_out_ready = 1'b1;
        send_frame(8'h78, 1'b1);
        exp_q = '{8'h78};
        check_popped("ready_byte");
        check("ready_count", 32'(fifo_count), 32'h0);
        check("ready_valid", 32'(data_out_valid), 32'h0);
        data_out_ready = 1'b0;
        wait_clks(BIT);

        // Back-to-back stream queued, then drained in order.
        popped.delete();
        send_frame(8'h78, 1'b1);
        send_frame(8'h79, 1'b1);
        send_frame(8'h7a, 1'b1);
        send_frame(8'h0d, 1'b1);
        wait_clks(2);
        check("stream_count", 32'(fifo_count), 32'h4);
        check("stream_head",  32'(data_out), 32'h78);
        check("stream_ov",    32'(overrun), 32'h0);
        pop_all(8);
        exp_q = '{8'h78, 8'h79, 8'h7a, 8'h0d};
        check_popped("stream_pop");
        check("stream_count_after", 32'(fifo_count), 32'h0);

        // Fifth byte into a full FIFO is dropped and flagged.
        popped.delete();
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        wait_clks(2);
        check("full_count", 32'(fifo_count), 32'h4);
        check("full_ov",    32'(overrun), 32'h1);
        check("full_head",  32'(data_out), 32'h01);
        pop_all(8);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_popped("full_pop");
        check("ov_sticky", 32'(overrun), 32'h1);
        err_clear = 1'b1;
        wait_clks(1);
        err_clear = 1'b0;
        wait_clks(1);
        check("ov_cleared", 32'(overrun), 32'h0);

        // Short low glitch on the idle line must be rejected.
        serial_in = 1'b0;
        wait_clks(10);
        serial_in = 1'b1;
        wait_clks(2 * BIT);
        check("glitch_valid", 32'(data_out_valid), 32'h0);
        check("glitch_count", 32'(fifo_count), 32'h0);
        check("glitch_fe",    32'(framing_error), 32'h0);
        check("glitch_ov",    32'(overrun), 32'h0);

        // Bad stop bit followed by a long low line, then a clean byte.
        send_frame(8'h55, 1'b0);
        wait_clks(3 * BIT);
        check("frame_fe",    32'(framing_error), 32'h1);
        check("frame_valid", 32'(data_out_valid), 32'h0);
        check("frame_count", 32'(fifo_count), 32'h0);
        serial_in = 1'b1;
        wait_clks(BIT);
        send_frame(8'h31, 1'b1);
        wait_clks(2);
        check("after_break_count", 32'(fifo_count), 32'h1);
        check("after_break_data",  32'(data_out), 32'h31);
        check("fe_sticky",         32'(framing_error), 32'h1);

        // Reset mid-frame with a queued byte and a set flag.
        serial_in = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 3; i++) begin
            serial_in = (8'ha5 >> i) & 8'h01;
            wait_clks(BIT);
        end
        rst       = 1'b1;
        serial_in = 1'b1;
        wait_clks(2);
        check("midrst_data",  32'(data_out), 32'h0);
        check("midrst_valid", 32'(data_out_valid), 32'h0);
        check("midrst_count", 32'(fifo_count), 32'h0);
        check("midrst_fe",    32'(framing_error), 32'h0);
        check("midrst_ov",    32'(overrun), 32'h0);
        rst = 1'b0;
        wait_clks(BIT);
        send_frame(8'h3e, 1'b1);
        wait_clks(2);
        check("post_rst_count", 32'(fifo_count), 32'h1);
        check("post_rst_data",  32'(data_out), 32'h3e);
        check("post_rst_fe",    32'(framing_error), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
